// File: rtl/and_gate_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// and_arb_pkg : shared defaults and round-robin winner search for the arbiter
// Rev 1.0
// ============================================================================
package and_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int MAX_REQ   = 16;
  localparam int WIN_W     = 4;

  // Returns {found, index}; scans ptr, ptr+1, ... wrapping at n.
  function automatic logic [WIN_W:0] rr_winner(
    input logic [MAX_REQ-1:0] req,
    input logic [WIN_W-1:0]   ptr,
    input logic [WIN_W:0]     n
  );
    logic [WIN_W:0]   idx;
    logic             found;
    logic [WIN_W-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + (WIN_W+1)'(k);
      if (idx >= n) idx = idx - n;
      if (!found && ((WIN_W+1)'(k) < n) && req[idx[WIN_W-1:0]]) begin
        found = 1'b1;
        win   = idx[WIN_W-1:0];
      end
    end
    return {found, win};
  endfunction

endpackage
`default_nettype wire

// File: rtl/and_gate_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational rotate-priority pick with one-hot grant encode
// Rev 1.0
// ============================================================================
module rr_pick
  import and_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [MAX_REQ-1:0] w_req_ext;
  logic [WIN_W-1:0]   w_ptr_ext;
  logic [WIN_W:0]     w_win;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[N_REQ-1:0]   = req;
    w_ptr_ext              = WIN_W'(ptr);
    w_win                  = rr_winner(w_req_ext, w_ptr_ext, (WIN_W+1)'(N_REQ));
    gnt_vld                = w_win[WIN_W];
    gnt_idx                = IDX_W'(w_win[WIN_W-1:0]);
    gnt                    = gnt_vld ? (N_REQ'(1) << gnt_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/and_gate_rr_arbiter.sv
`default_nettype none
// ============================================================================
// and_gate_rr_arbiter : round-robin sharing of one external 2-input AND gate
// Rev 1.0
// ============================================================================
module and_gate_rr_arbiter
  import and_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           op_a,
  input  logic [N_REQ-1:0]           op_b,
  output logic [N_REQ-1:0]           gnt,
  output logic                       gate_a,
  output logic                       gate_b,
  input  logic                       gate_y,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic                       rsp_y,
  output logic [CNT_W-1:0]           gnt_cnt,
  output logic                       err
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic             w_vld;
  logic             r_rsp_valid;
  logic [IDX_W-1:0] r_rsp_id;
  logic             r_rsp_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .gnt     (gnt),
    .gnt_idx (w_idx),
    .gnt_vld (w_vld)
  );

  // Gate inputs are forced low when idle so the shared gate sees a quiet bus.
  always_comb begin
    gate_a = w_vld & op_a[w_idx];
    gate_b = w_vld & op_b[w_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_vld;
      if (w_vld) begin
        r_ptr    <= (w_idx == IDX_W'(N_REQ-1)) ? '0 : w_idx + IDX_W'(1);
        r_rsp_id <= w_idx;
        r_rsp_y  <= gate_y;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
        if (gate_y != (gate_a & gate_b)) r_err <= 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign gnt_cnt   = r_cnt;
  assign err       = r_err;

`ifndef SYNTHESIS
  logic r_gnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_gnt_d <= 1'b0;
    else     r_gnt_d <= |gnt;
  end

  always_comb begin
    assert ($onehot0(gnt)) else $error("gnt is not one-hot-or-zero");
  end

  always @(posedge clk) begin
    if (!rst && rsp_valid) assert (r_gnt_d) else $error("rsp_valid without prior grant");
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_and_gate_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_and_gate_rr_arbiter : table-driven plus directed checks of the arbiter
// Rev 1.0
// ============================================================================
module tb_and_gate_rr_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic       fy;
    logic [3:0] gnt;
    logic       ga;
    logic       gb;
    logic       rv;
    logic [1:0] rid;
    logic       ry;
    logic [7:0] cnt;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, op_a, op_b, gnt;
  logic       gate_a, gate_b, gate_y, force_y;
  logic       rsp_valid, rsp_y, err;
  logic [1:0] rsp_id;
  logic [7:0] gnt_cnt;

  logic [3:0] req2, gnt2;
  logic       gate_a2, gate_b2, gate_y2, rsp_valid2, rsp_y2, err2;
  logic [1:0] rsp_id2, gnt_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behaves as the external AND gate, optionally stuck at 1.
  assign gate_y  = force_y ? 1'b1 : (gate_a & gate_b);
  assign gate_y2 = gate_a2 & gate_b2;

  and_gate_rr_arbiter #(.N_REQ(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
    .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .gnt_cnt(gnt_cnt), .err(err)
  );

  and_gate_rr_arbiter #(.N_REQ(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .op_a(4'b0000), .op_b(4'b0000), .gnt(gnt2),
    .gate_a(gate_a2), .gate_b(gate_b2), .gate_y(gate_y2), .rsp_valid(rsp_valid2),
    .rsp_id(rsp_id2), .rsp_y(rsp_y2), .gnt_cnt(gnt_cnt2), .err(err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, a, b, input logic fy,
                              input logic [3:0] g, input logic ga, gb, rv,
                              input logic [1:0] rid, input logic ry,
                              input logic [7:0] cnt, input logic e);
    vec_t v;
    v.req = r; v.a = a; v.b = b; v.fy = fy; v.gnt = g; v.ga = ga; v.gb = gb;
    v.rv = rv; v.rid = rid; v.ry = ry; v.cnt = cnt; v.err = e;
    return v;
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  vec_t tv[$];

  initial begin
    // all-requesters rotation, operands a=1111 b=0101
    tv.push_back(mk(4'b1111, 4'b1111, 4'b0101, 0, 4'b0001, 1, 1, 1, 2'd0, 1, 8'd1, 0));
    tv.push_back(mk(4'b1111, 4'b1111, 4'b0101, 0, 4'b0010, 1, 0, 1, 2'd1, 0, 8'd2, 0));
    tv.push_back(mk(4'b1111, 4'b1111, 4'b0101, 0, 4'b0100, 1, 1, 1, 2'd2, 1, 8'd3, 0));
    tv.push_back(mk(4'b1111, 4'b1111, 4'b0101, 0, 4'b1000, 1, 0, 1, 2'd3, 0, 8'd4, 0));
    tv.push_back(mk(4'b1111, 4'b1111, 4'b0101, 0, 4'b0001, 1, 1, 1, 2'd0, 1, 8'd5, 0));
    tv.push_back(mk(4'b1111, 4'b1111, 4'b0101, 0, 4'b0010, 1, 0, 1, 2'd1, 0, 8'd6, 0));
    tv.push_back(mk(4'b1111, 4'b1111, 4'b0101, 0, 4'b0100, 1, 1, 1, 2'd2, 1, 8'd7, 0));
    tv.push_back(mk(4'b1111, 4'b1111, 4'b0101, 0, 4'b1000, 1, 0, 1, 2'd3, 0, 8'd8, 0));
    // idle: gate quiet, response fields hold
    tv.push_back(mk(4'b0000, 4'b1111, 4'b0101, 0, 4'b0000, 0, 0, 0, 2'd3, 0, 8'd8, 0));
    // move ptr to 2, then alternate 3/1 on req=1010
    tv.push_back(mk(4'b0010, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1, 2'd1, 1, 8'd9, 0));
    tv.push_back(mk(4'b1010, 4'b1010, 4'b1000, 0, 4'b1000, 1, 1, 1, 2'd3, 1, 8'd10, 0));
    tv.push_back(mk(4'b1010, 4'b1010, 4'b1000, 0, 4'b0010, 1, 0, 1, 2'd1, 0, 8'd11, 0));
    tv.push_back(mk(4'b1010, 4'b1010, 4'b1000, 0, 4'b1000, 1, 1, 1, 2'd3, 1, 8'd12, 0));
    // requester 0 truth-table sweep, granted every cycle
    tv.push_back(mk(4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 1, 2'd0, 0, 8'd13, 0));
    tv.push_back(mk(4'b0001, 4'b0000, 4'b0001, 0, 4'b0001, 0, 1, 1, 2'd0, 0, 8'd14, 0));
    tv.push_back(mk(4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1, 2'd0, 0, 8'd15, 0));
    tv.push_back(mk(4'b0001, 4'b0001, 4'b0001, 0, 4'b0001, 1, 1, 1, 2'd0, 1, 8'd16, 0));
    // faulty gate: y=1 with (1,0) sets sticky err
    tv.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 1, 2'd0, 1, 8'd17, 1));
    tv.push_back(mk(4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd0, 1, 8'd17, 1));
    tv.push_back(mk(4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd0, 1, 8'd17, 1));

    rst = 1'b1; req = '0; op_a = '0; op_b = '0; force_y = 1'b0; req2 = '0;
    edge1();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_cnt", gnt_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_idle_gnt", gnt, 4'b0000);
    req = 4'b0100; op_a = 4'b0100; op_b = 4'b0100;
    #1;
    chk("rst_gnt_follows_req", gnt, 4'b0100);
    chk("rst_gate_a", gate_a, 1);
    req = '0;
    edge1();
    rst = 1'b0;

    foreach (tv[i]) begin
      req = tv[i].req; op_a = tv[i].a; op_b = tv[i].b; force_y = tv[i].fy;
      #1;
      chk($sformatf("v%0d_gnt", i), gnt, tv[i].gnt);
      chk($sformatf("v%0d_gate_a", i), gate_a, tv[i].ga);
      chk($sformatf("v%0d_gate_b", i), gate_b, tv[i].gb);
      edge1();
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tv[i].rv);
      chk($sformatf("v%0d_rsp_id", i), rsp_id, tv[i].rid);
      chk($sformatf("v%0d_rsp_y", i), rsp_y, tv[i].ry);
      chk($sformatf("v%0d_cnt", i), gnt_cnt, tv[i].cnt);
      chk($sformatf("v%0d_err", i), err, tv[i].err);
    end

    // err stays set until reset, then clears
    req = '0; force_y = 1'b0;
    edge1();
    chk("err_sticky", err, 1);
    rst = 1'b1;
    #1;
    chk("err_cleared_by_rst", err, 0);
    chk("cnt_cleared_by_rst", gnt_cnt, 0);
    edge1();
    rst = 1'b0;

    // async reset right after a grant to index 2
    req = 4'b1111; op_a = '0; op_b = '0;
    #1;
    chk("first_gnt_after_rst", gnt, 4'b0001);
    edge1();
    chk("seq_gnt1", gnt, 4'b0010);
    edge1();
    chk("seq_gnt2", gnt, 4'b0100);
    edge1();
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    chk("pre_rst_rsp_id", rsp_id, 2);
    chk("pre_rst_cnt", gnt_cnt, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_rsp_id", rsp_id, 0);
    chk("async_rst_cnt", gnt_cnt, 0);
    chk("async_rst_gnt_ptr0", gnt, 4'b0001);
    req = '0;
    #2;
    rst = 1'b0;
    edge1();
    chk("no_rsp_after_release", rsp_valid, 0);
    req = 4'b1111;
    #1;
    chk("post_rst_gnt", gnt, 4'b0001);
    edge1();
    chk("post_rst_rsp_id", rsp_id, 0);
    chk("post_rst_cnt", gnt_cnt, 1);
    req = '0;

    // 2-bit counter saturates at 3
    req2 = 4'b0001;
    edge1(); chk("sat_cnt1", gnt_cnt2, 2'd1);
    edge1(); chk("sat_cnt2", gnt_cnt2, 2'd2);
    edge1(); chk("sat_cnt3", gnt_cnt2, 2'd3);
    edge1(); chk("sat_cnt4", gnt_cnt2, 2'd3);
    edge1(); chk("sat_cnt5", gnt_cnt2, 2'd3);
    req2 = '0;
    edge1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
